reg_wr_ctrl: RTL and testbench

//  Write initiator for the reg_8/reg_16/reg_32 storage registers.
//  - Accepts a host write request with byte enables.
//  - Merges the enabled bytes into the register's current value (read-modify-write).
//  - Drives wr_data/wr_valid for one cycle, then waits for acknowledge to return high.
//  - Reports completion and an error code to the host.

---
 rtl/reg_wr_ctrl_if.sv | 26 ++
 rtl/reg_wr_ctrl.sv | 119 +++++++++++
 tb/tb_reg_wr_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/reg_wr_ctrl_if.sv
// Host request/response and storage-register write bus for reg_wr_ctrl.
// slave = controller view, master = host + register view.
interface reg_wr_ctrl_if #(
  parameter int WIDTH = 32
);
  logic               req_valid;
  logic               req_ready;
  logic [WIDTH-1:0]   req_data;
  logic [WIDTH/8-1:0] req_be;
  logic               done;
  logic [1:0]         err_code;
  logic [WIDTH-1:0]   reg_rd_data;
  logic               reg_ack;
  logic [WIDTH-1:0]   reg_wr_data;
  logic               reg_wr_valid;

  modport slave (
    input  req_valid, req_data, req_be, reg_rd_data, reg_ack,
    output req_ready, done, err_code, reg_wr_data, reg_wr_valid
  );

  modport master (
    output req_valid, req_data, req_be, reg_rd_data, reg_ack,
    input  req_ready, done, err_code, reg_wr_data, reg_wr_valid
  );
endinterface

// File: rtl/reg_wr_ctrl.sv
// Byte-enable read-modify-write initiator for reg_8/16/32 storage registers.
// Optional readback check enabled by defining READBACK_VERIFY_EN.
module reg_wr_lane (
  input  logic [7:0] wr,
  input  logic [7:0] rd,
  input  logic       be,
  output logic [7:0] merged
);
  assign merged = be ? wr : rd;
endmodule

module reg_wr_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 8
) (
  input  logic           clk,
  input  logic           reset,
  reg_wr_ctrl_if.slave   bus
);
  localparam int NUM_LANES = WIDTH / 8;
  localparam int CNT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    WAIT_ACK = 3'd2,
`ifdef READBACK_VERIFY_EN
    VERIFY   = 3'd3,
`endif
    DONE     = 3'd4
  } state_t;

  state_t                         state, state_n;
  logic [CNT_W-1:0]               cnt, cnt_n;
  logic [1:0]                     err_n;
  logic [WIDTH-1:0]               wr_data_n;
  logic [NUM_LANES-1:0][7:0]      lane_wr, lane_rd, lane_mg;
  logic [WIDTH-1:0]               merged;

  assign lane_wr = bus.req_data;
  assign lane_rd = bus.reg_rd_data;
  assign merged  = lane_mg;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    reg_wr_lane u_lane (
      .wr     (lane_wr[i]),
      .rd     (lane_rd[i]),
      .be     (bus.req_be[i]),
      .merged (lane_mg[i])
    );
  end

  // err_n only matters on the transition into DONE; elsewhere it stays 00.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    err_n     = 2'b00;
    wr_data_n = bus.reg_wr_data;
    case (state)
      IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          if (|bus.req_be) begin
            state_n   = WRITE;
            wr_data_n = merged;
          end else begin
            state_n   = DONE;
          end
        end
      end
      WRITE: begin
        state_n = WAIT_ACK;
        cnt_n   = '0;
      end
      WAIT_ACK: begin
        if (bus.reg_ack) begin
`ifdef READBACK_VERIFY_EN
          state_n = VERIFY;
`else
          state_n = DONE;
`endif
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_n = DONE;
          err_n   = 2'b01;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
`ifdef READBACK_VERIFY_EN
      VERIFY: begin
        state_n = DONE;
        err_n   = (bus.reg_rd_data == bus.reg_wr_data) ? 2'b00 : 2'b10;
      end
`endif
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      cnt              <= '0;
      bus.req_ready    <= 1'b0;
      bus.done         <= 1'b0;
      bus.err_code     <= 2'b00;
      bus.reg_wr_data  <= '0;
      bus.reg_wr_valid <= 1'b0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      bus.req_ready    <= (state_n == IDLE);
      bus.done         <= (state_n == DONE);
      bus.err_code     <= (state_n == DONE) ? err_n : 2'b00;
      bus.reg_wr_data  <= wr_data_n;
      bus.reg_wr_valid <= (state_n == WRITE);
    end
  end
endmodule

// File: tb/tb_reg_wr_ctrl.sv
// Scoreboard bench for reg_wr_ctrl with a behavioural reg_32 and fault stubs.
module tb_reg_wr_ctrl;
  localparam int W = 32;
`ifdef READBACK_VERIFY_EN
  localparam int         LAT_OK   = 4;
  localparam logic [1:0] ZERO_ERR = 2'b10;
`else
  localparam int         LAT_OK   = 3;
  localparam logic [1:0] ZERO_ERR = 2'b00;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  reg_wr_ctrl_if #(.WIDTH(W)) bus ();
  reg_wr_ctrl #(.WIDTH(W), .TIMEOUT(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Storage register model with stub modes
  logic [31:0] reg_q;
  logic        preload_en = 1'b0;
  logic [31:0] preload_val = '0;
  logic        stub_noack = 1'b0;
  logic        stub_zero = 1'b0;
  always @(posedge clk) begin
    if (preload_en) reg_q <= preload_val;
    else if (bus.reg_wr_valid) reg_q <= stub_zero ? 32'h0 : bus.reg_wr_data;
  end
  assign bus.reg_rd_data = reg_q;
  assign bus.reg_ack     = !stub_noack;

  typedef struct {
    logic [1:0]  err;
    int          lat;
    int          wc;
    logic [31:0] wd;
  } exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: times each transfer from its accept edge and checks on done
  int          cyc = 0, acc_cyc = 0, wr_seen = 0;
  logic [31:0] wr_cap = '0;
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (bus.reg_wr_valid) begin
        wr_seen++;
        wr_cap = bus.reg_wr_data;
      end
      if (bus.done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("err_code", {30'd0, bus.err_code}, {30'd0, e.err});
          chk("latency", cyc - acc_cyc, e.lat);
          chk("wr_pulses", wr_seen, e.wc);
          if (e.wc > 0) chk("wr_data", wr_cap, e.wd);
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        acc_cyc = cyc;
        wr_seen = 0;
      end
    end
  end

  task automatic issue(input logic [31:0] d, input logic [3:0] be, input logic [1:0] err,
                       input int lat, input int wc, input logic [31:0] wd, input bit expect_done);
    int  start;
    bit  got;
    exp_t e;
    if (expect_done) begin
      e.err = err; e.lat = lat; e.wc = wc; e.wd = wd;
      exp_q.push_back(e);
    end
    start = done_cnt;
    @(posedge clk); #1;
    bus.req_data = d; bus.req_be = be; bus.req_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("accept", {31'd0, got}, 32'd1);
    if (expect_done) begin
      for (int i = 0; i < 40 && done_cnt == start; i++) @(negedge clk);
      chk("done_seen", done_cnt - start, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_data = '0; bus.req_be = '0;
    // Reset held 3 cycles; preload the register meanwhile
    @(posedge clk); #1; preload_en = 1'b1; preload_val = 32'hAABBCCDD;
    @(posedge clk); #1; preload_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {28'd0, bus.req_ready, bus.done, bus.err_code}, 32'd0);
    chk("rst_wr", {31'd0, bus.reg_wr_valid}, 32'd0);
    chk("rst_wdata", bus.reg_wr_data, 32'd0);
    reset = 1'b1;
    #1 chk("ready_pre_edge", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    chk("ready_post_edge", {31'd0, bus.req_ready}, 32'd1);

    issue(32'h11223344, 4'b0101, 2'b00, LAT_OK, 1, 32'hAA22CC44, 1'b1);
    chk("reg_after_0101", reg_q, 32'hAA22CC44);
    issue(32'h55667788, 4'b1010, 2'b00, LAT_OK, 1, 32'h55227744, 1'b1);
    issue(32'h01020304, 4'b1000, 2'b00, LAT_OK, 1, 32'h01227744, 1'b1);
    issue(32'hDEADBEEF, 4'b0000, 2'b00, 1, 0, 32'h0, 1'b1);
    chk("reg_after_be0", reg_q, 32'h01227744);

    stub_zero = 1'b1;
    issue(32'h12345678, 4'b1111, ZERO_ERR, LAT_OK, 1, 32'h12345678, 1'b1);
    stub_zero = 1'b0;

    stub_noack = 1'b1;
    issue(32'hCAFEF00D, 4'b0011, 2'b01, 10, 1, 32'h0000F00D, 1'b1);

    // Abort in WAIT_ACK: reg_wr_data was nonzero, must clear at once
    issue(32'h0BADBEEF, 4'b1111, 2'b00, 0, 0, 32'h0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("abort_ctrl", {28'd0, bus.req_ready, bus.done, bus.err_code}, 32'd0);
    chk("abort_wr", {31'd0, bus.reg_wr_valid}, 32'd0);
    chk("abort_wdata", bus.reg_wr_data, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    stub_noack = 1'b0;
    issue(32'hFFFFFFFF, 4'b1111, 2'b00, LAT_OK, 1, 32'hFFFFFFFF, 1'b1);
    chk("reg_after_full", reg_q, 32'hFFFFFFFF);

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
